// File: rtl/calculate_4_issue_ctrl_if.sv
// Purpose: bundles the three streams of the calculate_4 issue controller.
//   operand stream : in_valid, in_ready, in_a, in_b
//   core handshake : calc_start, calc_done, calc_a, calc_b, calc_return
//   result stream  : out_valid, out_ready, out_data
// master = the controller, slave = its surroundings (producer, core, consumer).
interface calculate_4_issue_ctrl_if;
    localparam int unsigned DATA_W = 32;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;

    logic              calc_start;
    logic              calc_done;
    logic [DATA_W-1:0] calc_a;
    logic [DATA_W-1:0] calc_b;
    logic [DATA_W-1:0] calc_return;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        input  in_valid, in_a, in_b, calc_done, calc_return, out_ready,
        output in_ready, calc_start, calc_a, calc_b, out_valid, out_data
    );

    modport slave (
        output in_valid, in_a, in_b, calc_done, calc_return, out_ready,
        input  in_ready, calc_start, calc_a, calc_b, out_valid, out_data
    );
endinterface

// File: rtl/calculate_4_issue_ctrl.sv
// Purpose: sequences operand pairs into the calculate_4 core (ap_ctrl_hs style),
// buffers results in a small FIFO, guards the core with a done-timeout watchdog
// and counts completed operations.
// Ports:
//   ap_clk, ap_rst : clock, synchronous active-high reset
//   bus            : operand / core / result streams (master modport)
//   op_count       : results pushed into the FIFO, wraps at 16 bits
//   err_timeout    : sticky watchdog abort flag, cleared only by ap_rst
module calculate_4_issue_ctrl #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    calculate_4_issue_ctrl_if.master  bus,
    output logic [15:0]               op_count,
    output logic                      err_timeout
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned WD_W   = 16;
    localparam int unsigned OPS_W  = 16;

    localparam logic [WD_W-1:0]  TIMEOUT_VAL = WD_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [WD_W-1:0]     wd_q, wd_d, wd_inc;
    logic [OPS_W-1:0]    ops_q, ops_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    count_q, count_d, widx;
    logic [DATA_W-1:0]   data_q [DEPTH];
    logic [DATA_W-1:0]   data_d [DEPTH];
    logic                ready;
    logic                accept;
    logic                push;
    logic                pop;

    // Only one op is ever in flight, so accepting while count < DEPTH
    // reserves the slot its result will occupy.
    assign ready  = (state_q == IDLE) && (count_q < FULL_COUNT);
    assign accept = bus.in_valid && ready;
    assign pop    = bus.out_ready && (count_q != '0);

    // Next-state and datapath control of the issue FSM.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        wd_d    = wd_q;
        ops_d   = ops_q;
        err_d   = err_q;
        push    = 1'b0;
        wd_inc  = wd_q + WD_W'(1);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    wd_d    = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // done is checked first so it wins over a same-cycle timeout
                if (bus.calc_done) begin
                    push    = 1'b1;
                    ops_d   = ops_q + OPS_W'(1);
                    state_d = IDLE;
                end else begin
                    wd_d = wd_inc;
                    if (wd_inc == TIMEOUT_VAL) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result FIFO as a shift register: slot 0 is the registered head.
    always_comb begin
        count_d = count_q;
        widx    = count_q;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
        end

        if (pop) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                data_d[i] = data_q[i + 1];
            end
            // clear the vacated tail so an emptied FIFO presents zero
            data_d[DEPTH-1] = '0;
            widx            = count_q - CNT_W'(1);
        end

        if (push) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == widx) begin
                    data_d[i] = bus.calc_return;
                end
            end
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            wd_q    <= '0;
            ops_q   <= '0;
            err_q   <= 1'b0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            wd_q    <= wd_d;
            ops_q   <= ops_d;
            err_q   <= err_d;
            count_q <= count_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign bus.in_ready   = ready;
    assign bus.calc_start = (state_q == RUN);
    assign bus.calc_a     = a_q;
    assign bus.calc_b     = b_q;
    assign bus.out_valid  = (count_q != '0);
    assign bus.out_data   = data_q[0];
    assign op_count       = ops_q;
    assign err_timeout    = err_q;
endmodule

// File: tb/tb_calculate_4_issue_ctrl.sv
// Purpose: self-checking bench for calculate_4_issue_ctrl with a behavioural
// core (result = a + b after a chosen number of stall cycles) and a
// transaction-level reference model of the controller.
module tb_calculate_4_issue_ctrl;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 8;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic [15:0] op_count;
    logic        err_timeout;

    calculate_4_issue_ctrl_if bus ();

    calculate_4_issue_ctrl #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .bus         (bus),
        .op_count    (op_count),
        .err_timeout (err_timeout)
    );

    always #5 ap_clk = ~ap_clk;

    // Behavioural core: done rises after core_lat stall cycles of calc_start.
    int core_cnt = 0;
    int core_lat = 0;
    int pend_lat = 0;

    assign bus.calc_done   = bus.calc_start && (core_cnt == core_lat);
    assign bus.calc_return = bus.calc_a + bus.calc_b;

    always @(posedge ap_clk) begin
        if (ap_rst || !bus.calc_start || bus.calc_done) core_cnt <= 0;
        else                                            core_cnt <= core_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: an op either completes after lat+1 cycles with a+b,
    // or is abandoned after TIMEOUT cycles; results wait in a queue.
    bit          m_busy;
    bit          m_ok;
    int          m_left;
    logic [31:0] m_a, m_b;
    logic [15:0] m_ops;
    bit          m_err;
    logic [31:0] m_q[$];

    task automatic model_reset();
        m_busy = 1'b0;
        m_ok   = 1'b0;
        m_left = 0;
        m_a    = '0;
        m_b    = '0;
        m_ops  = '0;
        m_err  = 1'b0;
        m_q.delete();
    endtask

    task automatic step_model();
        bit exp_ready;
        bit acc;
        bit pop;
        exp_ready = !m_busy && (m_q.size() < int'(DEPTH));
        check("in_ready",   32'(bus.in_ready),   32'(exp_ready));
        check("calc_start", 32'(bus.calc_start), 32'(m_busy));
        if (m_busy) begin
            check("calc_a", bus.calc_a, m_a);
            check("calc_b", bus.calc_b, m_b);
        end
        check("out_valid", 32'(bus.out_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) check("out_data", bus.out_data, m_q[0]);
        check("op_count",    32'(op_count),    32'(m_ops));
        check("err_timeout", 32'(err_timeout), 32'(m_err));

        if (ap_rst) begin
            model_reset();
            return;
        end
        acc = bus.in_valid && exp_ready;
        pop = bus.out_ready && (m_q.size() > 0);
        if (pop) void'(m_q.pop_front());
        if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                if (m_ok) begin
                    m_q.push_back(m_a + m_b);
                    m_ops = m_ops + 16'd1;
                end else begin
                    m_err = 1'b1;
                end
                m_busy = 1'b0;
            end
        end
        if (acc) begin
            m_busy   = 1'b1;
            m_a      = bus.in_a;
            m_b      = bus.in_b;
            core_lat = pend_lat;
            m_ok     = (pend_lat < int'(TIMEOUT));
            m_left   = m_ok ? pend_lat + 1 : int'(TIMEOUT);
        end
    endtask

    // One clock cycle: drive at edge+1, check and advance the model at negedge.
    task automatic cycle(input bit v, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input bit r);
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.out_ready = r;
        pend_lat      = lat;
        @(negedge ap_clk);
        step_model();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic idle(input int n, input bit r);
        for (int k = 0; k < n; k++) cycle(1'b0, '0, '0, 0, r);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        ap_rst        = 1'b1;
        model_reset();
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        check("rst_calc_start", 32'(bus.calc_start), 32'd0);
        check("rst_calc_a",     bus.calc_a,          32'd0);
        check("rst_calc_b",     bus.calc_b,          32'd0);
        check("rst_out_valid",  32'(bus.out_valid),  32'd0);
        check("rst_out_data",   bus.out_data,        32'd0);
        check("rst_op_count",   32'(op_count),       32'd0);
        check("rst_err",        32'(err_timeout),    32'd0);
        @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;

        // single op, done = start: result visible two cycles after accept
        cycle(1'b1, 32'd5, 32'd7, 0, 1'b0);
        cycle(1'b0, '0, '0, 0, 1'b0);
        check("t1_out_valid", 32'(bus.out_valid), 32'd1);
        check("t1_out_data",  bus.out_data,       32'h0000000C);
        check("t1_op_count",  32'(op_count),      32'd1);
        idle(3, 1'b1);

        // backpressure: producer keeps offering, consumer stalled
        for (int k = 0; k < 20; k++) cycle(1'b1, $urandom, $urandom, 0, 1'b0);
        check("t2_op_count", 32'(op_count),     32'd5);
        check("t2_in_ready", 32'(bus.in_ready), 32'd0);
        idle(12, 1'b1);

        // core stalls three cycles
        cycle(1'b1, 32'hDEADBEE0, 32'h0000000F, 3, 1'b0);
        idle(6, 1'b0);
        check("t3_out_data", bus.out_data,    32'hDEADBEEF);
        check("t3_op_count", 32'(op_count),   32'd6);
        check("t3_err",      32'(err_timeout), 32'd0);
        idle(3, 1'b1);

        // done on the last watchdog cycle still completes
        cycle(1'b1, 32'd1, 32'd2, int'(TIMEOUT) - 1, 1'b1);
        idle(12, 1'b1);
        check("edge_op_count", 32'(op_count),    32'd7);
        check("edge_err",      32'(err_timeout), 32'd0);

        // core never answers
        cycle(1'b1, 32'd3, 32'd4, 1000, 1'b1);
        idle(12, 1'b1);
        check("t4_err",       32'(err_timeout),   32'd1);
        check("t4_op_count",  32'(op_count),      32'd7);
        check("t4_out_valid", 32'(bus.out_valid), 32'd0);
        check("t4_in_ready",  32'(bus.in_ready),  32'd1);

        // push and pop together with DEPTH-1 entries held
        for (int k = 0; k < 20 && m_q.size() < int'(DEPTH) - 1; k++)
            cycle(!m_busy, $urandom, $urandom, 0, 1'b0);
        cycle(1'b1, 32'h11110000, 32'h00002222, 0, 1'b0);
        cycle(1'b0, '0, '0, 0, 1'b1);
        check("t5_in_ready", 32'(bus.in_ready), 32'd1);
        cycle(1'b1, 32'h0000AAAA, 32'h55550000, 0, 1'b0);
        cycle(1'b0, '0, '0, 0, 1'b0);
        check("t5_full", 32'(bus.in_ready), 32'd0);
        idle(8, 1'b1);

        // randomized traffic, occasional watchdog aborts
        for (int k = 0; k < 3000; k++) begin
            int lat;
            lat = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 11))
                                              : int'($urandom_range(0, 3));
            cycle($urandom_range(0, 99) < 60, $urandom, $urandom, lat,
                  $urandom_range(0, 99) < 50);
        end
        idle(16, 1'b0);

        // reset in the middle of an op with results buffered
        cycle(1'b1, $urandom, $urandom, 0, 1'b0);
        cycle(1'b0, '0, '0, 0, 1'b0);
        cycle(1'b1, $urandom, $urandom, 5, 1'b0);
        idle(2, 1'b0);
        ap_rst = 1'b1;
        cycle(1'b0, '0, '0, 0, 1'b0);
        ap_rst = 1'b0;
        check("t6_calc_start", 32'(bus.calc_start), 32'd0);
        check("t6_out_valid",  32'(bus.out_valid),  32'd0);
        check("t6_out_data",   bus.out_data,        32'd0);
        check("t6_op_count",   32'(op_count),       32'd0);
        check("t6_err",        32'(err_timeout),    32'd0);
        check("t6_in_ready",   32'(bus.in_ready),   32'd1);
        for (int k = 0; k < 200; k++)
            cycle($urandom_range(0, 99) < 70, $urandom, $urandom,
                  int'($urandom_range(0, 2)), $urandom_range(0, 99) < 60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
